// File: rtl/aes_pkg.sv
// Shared AES definitions for the round sequencer and its neighbours.
//   AES_BLOCK_W     : width of one AES state / block
//   AES128_ROUNDS   : rounds after the initial AddRoundKey for AES-128
//   aes_block_t     : one 128-bit AES block
//   aes_seq_state_e : control states of the round sequencer
package aes_pkg;

  localparam int unsigned AES_BLOCK_W   = 128;
  localparam int unsigned AES128_ROUNDS = 10;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } aes_seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller.
// Owns the 128-bit state register, takes one plaintext block per in_valid/in_ready
// handshake, whitens it with round key 0, then runs NUM_ROUNDS rounds through an
// external fixed-latency round datapath, adding the round key from the external
// key store after each. The ciphertext is held on out_block until out_ready.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_block  : plaintext input handshake
//   out_valid/out_ready/out_block: ciphertext output handshake
//   rk_idx / rk                 : round key index out, round key back (same cycle)
//   dp_start/dp_in/dp_last      : datapath launch pulse, state, final-round flag
//   dp_out                      : datapath result, DP_LATENCY cycles after dp_start
//   busy                        : high whenever not idle
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned DP_LATENCY = 2,
  parameter int unsigned CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic [CNT_W-1:0]       rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk,
  output logic                   dp_start,
  output logic [AES_BLOCK_W-1:0] dp_in,
  output logic                   dp_last,
  input  logic [AES_BLOCK_W-1:0] dp_out,
  output logic                   busy
);

  localparam int unsigned WCNT_W = $clog2(DP_LATENCY + 1);

  aes_seq_state_e    fsm_q, fsm_d;
  logic [CNT_W-1:0]  round_q, round_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  aes_block_t        state_q, state_d;
  logic              is_last;

  assign is_last = (round_q == CNT_W'(NUM_ROUNDS));
  assign dp_in   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      wcnt_q  <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      wcnt_q  <= wcnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    wcnt_d    = wcnt_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_block = '0;
    dp_start  = 1'b0;
    dp_last   = 1'b0;
    rk_idx    = '0;
    busy      = 1'b1;

    case (fsm_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_block ^ rk;
          round_d = CNT_W'(1);
          fsm_d   = ISSUE;
        end
      end
      ISSUE: begin
        dp_start = 1'b1;
        dp_last  = is_last;
        rk_idx   = round_q;
        wcnt_d   = WCNT_W'(DP_LATENCY);
        fsm_d    = WAIT;
      end
      WAIT: begin
        dp_last = is_last;
        rk_idx  = round_q;
        wcnt_d  = wcnt_q - WCNT_W'(1);
        // wcnt_q reaches 1 in exactly the cycle dp_out carries this round's result
        if (wcnt_q == WCNT_W'(1)) begin
          state_d = dp_out ^ rk;
          if (is_last) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + CNT_W'(1);
            fsm_d   = ISSUE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_block = state_q;
        if (out_ready) begin
          round_d = '0;
          fsm_d   = IDLE;
        end
      end
      default: begin
        busy  = 1'b0;
        fsm_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (DP_LATENCY 2 and 1) share the
// host-side stimulus; the bench supplies an AES key store and a round datapath,
// and a cycle-position model predicts every output from the accept time.
module tb_aes_round_sequencer;

  localparam int N = 10;
  localparam int CW = 4;
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef logic [10:0][127:0] rs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready;
  logic [127:0] in_block, key;
  rs_t ks;
  logic [1:0] in_ready_w, out_valid_w, dp_start_w, dp_last_w, busy_w;
  logic [1:0][127:0] out_block_w, dp_in_w, dp_out_w, rk_w;
  logic [1:0][CW-1:0] rk_idx_w;
  logic [7:0] sbox_t [256];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  aes_round_sequencer #(.NUM_ROUNDS(N), .DP_LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_block(in_block), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_block(out_block_w[0]), .rk_idx(rk_idx_w[0]), .rk(rk_w[0]),
    .dp_start(dp_start_w[0]), .dp_in(dp_in_w[0]), .dp_last(dp_last_w[0]),
    .dp_out(dp_out_w[0]), .busy(busy_w[0]));

  aes_round_sequencer #(.NUM_ROUNDS(N), .DP_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_block(in_block), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_block(out_block_w[1]), .rk_idx(rk_idx_w[1]), .rk(rk_w[1]),
    .dp_start(dp_start_w[1]), .dp_in(dp_in_w[1]), .dp_last(dp_last_w[1]),
    .dp_out(dp_out_w[1]), .busy(busy_w[1]));

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a);
    return {a[6:0], a[7]};
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic rs_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rs_t o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns; no key addition
  function automatic logic [127:0] rnd(input logic [127:0] s, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r + 4*((c+r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
        b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  // entry j = state presented to round j+1; entry 10 = ciphertext
  function automatic rs_t aes_states(input logic [127:0] pt, input logic [127:0] k);
    rs_t kk, o;
    logic [127:0] s;
    kk = expand(k);
    s = pt ^ kk[0];
    o[0] = s;
    for (int j = 1; j <= 10; j++) begin
      s = rnd(s, j == 10) ^ kk[j];
      o[j] = s;
    end
    return o;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    key = k;
    ks = expand(k);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- external key store and datapath ----------------
  assign rk_w[0] = (rk_idx_w[0] <= CW'(10)) ? ks[rk_idx_w[0]] : '0;
  assign rk_w[1] = (rk_idx_w[1] <= CW'(10)) ? ks[rk_idx_w[1]] : '0;

  logic [127:0] p0a, p0b, p1a;
  always @(posedge clk) begin
    p0a <= dp_start_w[0] ? rnd(dp_in_w[0], dp_last_w[0]) : r128();
    p0b <= p0a;
    p1a <= dp_start_w[1] ? rnd(dp_in_w[1], dp_last_w[1]) : r128();
  end
  assign dp_out_w[0] = p0b;
  assign dp_out_w[1] = p1a;

  int n_start [2] = '{0, 0};
  int n_last  [2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dp_start_w[i]) n_start[i] <= n_start[i] + 1;
      if (dp_last_w[i])  n_last[i]  <= n_last[i] + 1;
    end
  end

  // ---------------- behavioural model ----------------
  // m_k = cycles since accept; phase within a round is derived arithmetically
  bit  m_act [2] = '{0, 0};
  int  m_k   [2] = '{0, 0};
  rs_t m_rs  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0;
      end else if (!m_act[i]) begin
        if (in_valid) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 1;
          m_rs[i]  <= aes_states(in_block, key);
        end
      end else if (m_k[i] <= N * (lat(i) + 1)) begin
        m_k[i] <= m_k[i] + 1;
      end else if (out_ready) begin
        m_act[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic e_valid, e_start, e_last;
        logic [CW-1:0] e_idx;
        logic [127:0] e_blk;
        int k, l, p, r;
        e_valid = 1'b0; e_start = 1'b0; e_last = 1'b0; e_idx = '0; e_blk = '0;
        l = lat(i);
        k = m_k[i];
        if (m_act[i] && k <= N * (l + 1)) begin
          p = (k - 1) % (l + 1);
          r = (k - 1) / (l + 1) + 1;
          e_start = (p == 0);
          e_last  = (r == N);
          e_idx   = CW'(r);
          if (p == 0) check("dp_in", i, dp_in_w[i], m_rs[i][r-1]);
        end else if (m_act[i]) begin
          e_valid = 1'b1;
          e_blk   = m_rs[i][N];
        end
        check("in_ready",  i, 128'(in_ready_w[i]),  128'(!m_act[i]));
        check("busy",      i, 128'(busy_w[i]),      128'(m_act[i]));
        check("out_valid", i, 128'(out_valid_w[i]), 128'(e_valid));
        check("dp_start",  i, 128'(dp_start_w[i]),  128'(e_start));
        check("dp_last",   i, 128'(dp_last_w[i]),   128'(e_last));
        check("rk_idx",    i, 128'(rk_idx_w[i]),    128'(e_idx));
        check("out_block", i, out_block_w[i],       e_blk);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  // Both instances idle on entry; leaves both in DONE with out_ready low.
  task automatic fips_block;
    int n;
    int lt [2];
    int st [2];
    int lc;
    logic [127:0] ct [2];
    lt[0] = 0; lt[1] = 0; ct[0] = '0; ct[1] = '0;
    st[0] = n_start[0]; st[1] = n_start[1]; lc = n_last[0];
    in_block = FPT; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while ((lt[0] == 0 || lt[1] == 0) && n < 100) begin
      tick;
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        in_block = r128();
      end
      for (int i = 0; i < 2; i++)
        if (lt[i] == 0 && out_valid_w[i]) begin
          lt[i] = n;
          ct[i] = out_block_w[i];
        end
    end
    check("latency_L2", 0, 128'(lt[0]), 128'd31);
    check("latency_L1", 1, 128'(lt[1]), 128'd21);
    check("fips_ct", 0, ct[0], FCT);
    check("fips_ct", 1, ct[1], FCT);
    check("start_pulses", 0, 128'(n_start[0] - st[0]), 128'd10);
    check("start_pulses", 1, 128'(n_start[1] - st[1]), 128'd10);
    check("last_cycles", 0, 128'(n_last[0] - lc), 128'd3);
  endtask

  task automatic drain;
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (in_ready_w != 2'b11 && n < 200) begin
      tick;
      n++;
    end
    check("drain_idle", 0, 128'(in_ready_w), 128'(2'b11));
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int cnt [2];
    int t1 [2];
    int t2 [2];
    logic [127:0] c1 [2];
    logic [127:0] c2 [2];
    logic [127:0] pt2;
    rs_t e2;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] a, inv;
      a = 8'(v);
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gm(inv, a);
      sbox_t[v] = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
    end
    check("sbox_00", 0, 128'(sbox_t[8'h00]), 128'h63);
    check("sbox_53", 0, 128'(sbox_t[8'h53]), 128'hed);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
    set_key(FKEY);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready",  i, 128'(in_ready_w[i]),  128'd1);
      check("rst_out_valid", i, 128'(out_valid_w[i]), 128'd0);
      check("rst_busy",      i, 128'(busy_w[i]),      128'd0);
      check("rst_rk_idx",    i, 128'(rk_idx_w[i]),    128'd0);
      check("rst_out_block", i, out_block_w[i],       128'd0);
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // FIPS vector, then backpressure with in_valid noise
    fips_block();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'(c % 2 == 0);
      in_block = r128();
      tick;
      check("bp_out_valid", 0, 128'(out_valid_w[0]), 128'd1);
      check("bp_out_block", 0, out_block_w[0], FCT);
      check("bp_in_ready",  0, 128'(in_ready_w[0]), 128'd0);
    end
    in_valid = 1'b1; in_block = FPT; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("post_hs_in_ready", 0, 128'(in_ready_w[0]), 128'd1);
    tick;
    in_valid = 1'b0;
    check("next_accept_busy", 0, 128'(busy_w[0]), 128'd1);
    drain();

    // Reset during round 5 wait
    in_block = FPT; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (13) tick;
    check("r5_rk_idx",   0, 128'(rk_idx_w[0]),   128'd5);
    check("r5_dp_start", 0, 128'(dp_start_w[0]), 128'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("abort_out_valid", i, 128'(out_valid_w[i]), 128'd0);
      check("abort_in_ready",  i, 128'(in_ready_w[i]),  128'd1);
      check("abort_busy",      i, 128'(busy_w[i]),      128'd0);
      check("abort_dp_start",  i, 128'(dp_start_w[i]),  128'd0);
    end
    fips_block();
    drain();

    // Back-to-back with out_ready tied high
    pt2 = r128();
    e2 = aes_states(pt2, key);
    cnt[0] = 0; cnt[1] = 0; t1[0] = 0; t1[1] = 0; t2[0] = 0; t2[1] = 0;
    c1[0] = '0; c1[1] = '0; c2[0] = '0; c2[1] = '0;
    in_block = FPT; in_valid = 1'b1; out_ready = 1'b1; n = 0;
    while ((cnt[0] < 2 || cnt[1] < 2) && n < 150) begin
      tick;
      n++;
      if (n == 1) in_block = pt2;
      for (int i = 0; i < 2; i++)
        if (out_valid_w[i] && cnt[i] < 2) begin
          if (cnt[i] == 0) begin
            t1[i] = n; c1[i] = out_block_w[i];
          end else begin
            t2[i] = n; c2[i] = out_block_w[i];
          end
          cnt[i]++;
        end
    end
    for (int i = 0; i < 2; i++) begin
      check("b2b_ct1", i, c1[i], FCT);
      check("b2b_ct2", i, c2[i], e2[10]);
    end
    check("b2b_gap", 0, 128'(t2[0] - t1[0]), 128'd32);
    check("b2b_gap", 1, 128'(t2[1] - t1[1]), 128'd22);
    drain();

    // Randomized traffic under several keys
    for (int seg = 0; seg < 4; seg++) begin
      rst = 1'b1;
      set_key(r128());
      tick;
      rst = 1'b0;
      for (int c = 0; c < 300; c++) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_block  = r128();
        out_ready = ($urandom_range(0, 3) != 0);
        tick;
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
